// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB field layout, write-back
// source encodings and the MEM-stage access FSM state type.
package cpu_pkg;

  localparam int unsigned ExMemW = 139;
  localparam int unsigned MemWbW = 38;

  localparam int unsigned StoreLsb    = 0;
  localparam int unsigned AluLsb      = 32;
  localparam int unsigned WrLsb       = 64;
  localparam int unsigned MemReadBit  = 69;
  localparam int unsigned MemWriteBit = 70;
  localparam int unsigned RegWriteBit = 71;
  localparam int unsigned MemToRegLsb = 72;
  localparam int unsigned Pc4Lsb      = 74;
  localparam int unsigned LuDataLsb   = 106;
  localparam int unsigned LuOpBit     = 138;

  localparam int unsigned WbDataLsb   = 0;
  localparam int unsigned WbRegLsb    = 32;
  localparam int unsigned WbRegWrBit  = 37;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

  typedef enum logic {StIdle, StWait} mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-bus request sequencer: issues the request, counts wait states, aborts
// on timeout and raises the upstream stall and the error pulses.
module mem_access_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  logic aligned_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic complete_o,
  output logic abort_o,
  output logic misalign_err_o,
  output logic bus_err_o
);

  localparam int unsigned CntW = $clog2(Timeout);

  mem_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req, complete, abort;
  logic              misalign_q, bus_err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access_i && aligned_i) begin
          req = 1'b1;
          if (ack_i) begin
            complete = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(1);
          end
        end
      end
      StWait: begin
        req = 1'b1;
        if (ack_i) begin
          complete = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end else if (cnt_q == CntW'(Timeout - 1)) begin
          abort   = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset kills an outstanding request at once; the access is not retried.
  assign req_o          = req & ~rst_i;
  assign complete_o     = complete & ~rst_i;
  assign abort_o        = abort & ~rst_i;
  assign stall_o        = req_o & ~ack_i & ~abort_o;
  assign misalign_err_o = misalign_q;
  assign bus_err_o      = bus_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= (state_q == StIdle) && access_i && !aligned_i;
      bus_err_q  <= abort;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data bus from EX_MEM, selects the write-back
// value and loads MEM_WB, inserting bubbles while the access is outstanding.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ExMemW-1:0]   EX_MEM,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic                stall,
  output logic [31:0]         fwd_data,
  output logic [MemWbW-1:0]   MEM_WB,
  output logic                misalign_err,
  output logic                bus_err
);

  logic [31:0] alu_res, pc_plus4, lu_data, wb_data;
  logic [4:0]  wr_reg;
  logic [1:0]  mem_to_reg;
  logic        mem_read, reg_write, lu_op, access, aligned, complete, abort;
  logic [MemWbW-1:0] mem_wb_q, mem_wb_d;

  assign mem_wdata  = EX_MEM[StoreLsb +: 32];
  assign alu_res    = EX_MEM[AluLsb +: 32];
  assign wr_reg     = EX_MEM[WrLsb +: 5];
  assign mem_read   = EX_MEM[MemReadBit];
  assign mem_we     = EX_MEM[MemWriteBit];
  assign reg_write  = EX_MEM[RegWriteBit];
  assign mem_to_reg = EX_MEM[MemToRegLsb +: 2];
  assign pc_plus4   = EX_MEM[Pc4Lsb +: 32];
  assign lu_data    = EX_MEM[LuDataLsb +: 32];
  assign lu_op      = EX_MEM[LuOpBit];

  assign mem_addr = alu_res;
  assign access   = mem_read | mem_we;
  assign aligned  = (alu_res[1:0] == 2'b00);

  mem_access_fsm #(
    .Timeout (TIMEOUT)
  ) u_fsm (
    .clk_i          (clk),
    .rst_i          (reset),
    .access_i       (access),
    .aligned_i      (aligned),
    .ack_i          (mem_ack),
    .req_o          (mem_req),
    .stall_o        (stall),
    .complete_o     (complete),
    .abort_o        (abort),
    .misalign_err_o (misalign_err),
    .bus_err_o      (bus_err)
  );

  always_comb begin
    if (mem_to_reg == WbPc4) begin
      fwd_data = pc_plus4;
    end else if (lu_op) begin
      fwd_data = lu_data;
    end else begin
      fwd_data = alu_res;
    end
  end

  // Misaligned or aborted loads never complete, so they write back zero.
  always_comb begin
    if (mem_to_reg == WbMem) begin
      wb_data = complete ? mem_rdata : 32'h0;
    end else begin
      wb_data = fwd_data;
    end
    if (stall) begin
      mem_wb_d = '0;
    end else begin
      mem_wb_d = {reg_write & (wr_reg != 5'd0), wr_reg, wb_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign MEM_WB = mem_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4 and hand-computed expectations.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic [138:0] ex_mem;
  logic         mem_req, mem_we, mem_ack, stall, misalign_err, bus_err;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, fwd_data;
  logic [37:0]  mem_wb;

  int checks = 0;
  int errors = 0;

  mem_stage #(
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .EX_MEM       (ex_mem),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .fwd_data     (fwd_data),
    .MEM_WB       (mem_wb),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [138:0] mk(input logic [31:0] sd, input logic [31:0] alu,
                                      input logic [4:0] wr, input logic mr, input logic mw,
                                      input logic rw, input logic [1:0] m2r,
                                      input logic [31:0] pc4, input logic [31:0] lud,
                                      input logic luop);
    return {luop, lud, pc4, m2r, rw, mw, mr, wr, alu, sd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    ex_mem    = '0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    check_eq("rst_mem_wb", 64'(mem_wb), 64'h0);
    check_eq("rst_req", 64'(mem_req), 64'h0);
    check_eq("rst_errs", 64'({misalign_err, bus_err}), 64'h0);
    tick();
    tick();
    reset = 1'b0;

    // ALU op to R5; a stray ack with no request must be ignored.
    ex_mem    = mk(32'h0, 32'h0000_1234, 5'd5, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("alu_fwd", 64'(fwd_data), 64'h1234);
    check_eq("alu_stall", 64'(stall), 64'h0);
    check_eq("alu_req", 64'(mem_req), 64'h0);
    tick();
    check_eq("alu_wb", 64'(mem_wb), 64'({1'b1, 5'd5, 32'h0000_1234}));
    mem_ack = 1'b0;

    // Load from 0x100 acked after 3 wait cycles.
    ex_mem = mk(32'h0, 32'h0000_0100, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("ld_stall%0d", i), 64'(stall), 64'h1);
      check_eq($sformatf("ld_req%0d", i), 64'(mem_req), 64'h1);
      tick();
      check_eq($sformatf("ld_bubble%0d", i), 64'(mem_wb), 64'h0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("ld_ack_stall", 64'(stall), 64'h0);
    tick();
    mem_ack = 1'b0;
    check_eq("ld_wb", 64'(mem_wb), 64'({1'b1, 5'd7, 32'hCAFE_F00D}));

    // Zero-wait store to 0x200.
    ex_mem  = mk(32'hDEAD_BEEF, 32'h0000_0200, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0,
                 1'b0);
    mem_ack = 1'b1;
    #1;
    check_eq("st_we", 64'(mem_we), 64'h1);
    check_eq("st_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check_eq("st_addr", 64'(mem_addr), 64'h200);
    check_eq("st_stall", 64'(stall), 64'h0);
    tick();
    mem_ack = 1'b0;
    check_eq("st_regwrite", 64'(mem_wb[37]), 64'h0);

    // Misaligned load from 0x103.
    ex_mem    = mk(32'h0, 32'h0000_0103, 5'd8, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    mem_rdata = 32'h1357_9BDF;
    #1;
    check_eq("mis_req", 64'(mem_req), 64'h0);
    check_eq("mis_stall", 64'(stall), 64'h0);
    tick();
    check_eq("mis_err", 64'(misalign_err), 64'h1);
    check_eq("mis_wb", 64'(mem_wb), 64'({1'b1, 5'd8, 32'h0}));
    ex_mem = '0;
    tick();
    check_eq("mis_err_pulse", 64'(misalign_err), 64'h0);

    // Timeout abort on a load from 0x300 (TIMEOUT=4).
    ex_mem    = mk(32'h0, 32'h0000_0300, 5'd9, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("to_stall%0d", i), 64'(stall), 64'h1);
      tick();
      check_eq($sformatf("to_bubble%0d", i), 64'(mem_wb), 64'h0);
      check_eq($sformatf("to_buserr%0d", i), 64'(bus_err), 64'h0);
    end
    #1;
    check_eq("to_abort_stall", 64'(stall), 64'h0);
    tick();
    check_eq("to_bus_err", 64'(bus_err), 64'h1);
    check_eq("to_wb", 64'(mem_wb), 64'({1'b1, 5'd9, 32'h0}));
    ex_mem = '0;
    tick();
    check_eq("to_bus_err_pulse", 64'(bus_err), 64'h0);

    // jal: write back PC+4.
    ex_mem = mk(32'h0, 32'h0000_0999, 5'd31, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0040,
                32'hAAAA_0000, 1'b1);
    tick();
    check_eq("jal_wb", 64'(mem_wb), 64'({1'b1, 5'd31, 32'h0000_0040}));

    // lui: write back LUData.
    ex_mem = mk(32'h0, 32'h0000_1111, 5'd3, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0044,
                32'hABCD_0000, 1'b1);
    tick();
    check_eq("lui_wb", 64'(mem_wb), 64'({1'b1, 5'd3, 32'hABCD_0000}));

    // Write to R0 is suppressed.
    ex_mem = mk(32'h0, 32'h0000_0077, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    check_eq("r0_wb", 64'(mem_wb), 64'({1'b0, 5'd0, 32'h0000_0077}));

    // Reset while waiting.
    ex_mem = mk(32'h0, 32'h0000_0400, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 1'b0);
    tick();
    check_eq("rw_stall", 64'(stall), 64'h1);
    reset = 1'b1;
    #1;
    check_eq("rw_req", 64'(mem_req), 64'h0);
    check_eq("rw_stall_off", 64'(stall), 64'h0);
    check_eq("rw_wb", 64'(mem_wb), 64'h0);
    ex_mem = '0;
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
